// File: rtl/line_clear_engine_if.sv
// Board RAM row port between the line-clear engine (master) and the board RAM (slave).
// Read data returns exactly one cycle after RAM_RE.
interface line_clear_engine_if;
   logic [10:0] RAM_ROW_ADDR;
   logic        RAM_RE;
   logic        RAM_WE;
   logic [31:0] RAM_READDATA;
   logic [31:0] RAM_WRITEDATA;

   modport master (
      output RAM_ROW_ADDR, RAM_RE, RAM_WE, RAM_WRITEDATA,
      input  RAM_READDATA
   );

   modport slave (
      input  RAM_ROW_ADDR, RAM_RE, RAM_WE, RAM_WRITEDATA,
      output RAM_READDATA
   );
endinterface

// File: rtl/line_clear_engine.sv
// Post-lock line clear: scans rows bottom-up, compacts surviving rows in place, zero-fills the top.
// Optional LINE_CLEAR_SCORE_EN adds clear_all input and a saturating 20-bit score output.
module line_clear_engine #(
   parameter int ROWS      = 22,
   parameter int COLS      = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  lines_cleared,
`ifdef LINE_CLEAR_SCORE_EN
   input  logic        clear_all,
   output logic [19:0] score,
`endif
   line_clear_engine_if.master ram
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EVAL,
      S_FILL,
      S_DONE
   } state_t;

   // Bit 5 of each pointer is the underflow flag; bits 4:0 are the row index.
   localparam logic [5:0]  PTR_INIT = 6'(ROWS - 1);
   localparam logic [10:0] BASE     = 11'(BASE_ADDR);

   state_t      state, state_next;
   logic        start_q;
   logic [5:0]  rd_ptr, wr_ptr;
   logic [5:0]  rd_dec, wr_dec, wr_after_eval;
   logic [4:0]  cnt;
   logic [4:0]  held_count;
   logic        row_full;
   logic        eval_write;

   assign rd_dec        = rd_ptr - 6'd1;
   assign wr_dec        = wr_ptr - 6'd1;
   assign wr_after_eval = row_full ? wr_ptr : wr_dec;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      row_full = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (c < COLS && ram.RAM_READDATA[2*c +: 2] == 2'b00) begin
            row_full = 1'b0;
         end
      end
   end

   assign eval_write = (state == S_EVAL) && !row_full && (wr_ptr != rd_ptr);

   // NOTE: sequential state uses non-blocking assignments only; blocking is reserved for always_comb.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: if (start_q) state_next = S_READ;
         S_READ: state_next = S_EVAL;
         S_EVAL: begin
            if (rd_ptr == 6'd0) begin
               state_next = wr_after_eval[5] ? S_DONE : S_FILL;
            end else begin
               state_next = S_READ;
            end
         end
         S_FILL: if (wr_dec[5]) state_next = S_DONE;
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // start is registered first so busy rises one edge after start is sampled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_q    <= 1'b0;
         rd_ptr     <= 6'd0;
         wr_ptr     <= 6'd0;
         cnt        <= 5'd0;
         held_count <= 5'd0;
      end else begin
         start_q <= (state == S_IDLE) && start && !start_q;
         unique case (state)
            S_IDLE: begin
               if (start_q) begin
                  rd_ptr     <= PTR_INIT;
                  wr_ptr     <= PTR_INIT;
                  cnt        <= 5'd0;
                  held_count <= 5'd0;
               end
            end
            S_EVAL: begin
               if (row_full) begin
                  cnt <= cnt + 5'd1;
               end
               wr_ptr <= wr_after_eval;
               rd_ptr <= rd_dec;
            end
            S_FILL: wr_ptr <= wr_dec;
            S_DONE: held_count <= cnt;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy              = (state != S_IDLE);
      done              = (state == S_DONE);
      lines_cleared     = done ? cnt : held_count;
      ram.RAM_RE        = (state == S_READ);
      ram.RAM_WE        = (state == S_FILL) || eval_write;
      ram.RAM_ROW_ADDR  = 11'd0;
      ram.RAM_WRITEDATA = 32'd0;
      if (state == S_READ) begin
         ram.RAM_ROW_ADDR = BASE + 11'(rd_ptr[4:0]);
      end else if (ram.RAM_WE) begin
         ram.RAM_ROW_ADDR = BASE + 11'(wr_ptr[4:0]);
      end
      // Surviving rows move verbatim, including the cells outside the fullness check.
      if (eval_write) begin
         ram.RAM_WRITEDATA = ram.RAM_READDATA;
      end
   end

`ifdef LINE_CLEAR_SCORE_EN
   logic [19:0] award;
   logic [20:0] score_sum;

   always_comb begin
      award = 20'd800;
      unique case (cnt)
         5'd0:    award = 20'd0;
         5'd1:    award = 20'd100;
         5'd2:    award = 20'd300;
         5'd3:    award = 20'd500;
         default: award = 20'd800;
      endcase
   end

   assign score_sum = {1'b0, score} + {1'b0, award};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         score <= 20'd0;
      end else if (clear_all) begin
         score <= 20'd0;
      end else if (state == S_DONE) begin
         score <= score_sum[20] ? 20'hF_FFFF : score_sum[19:0];
      end
   end
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine with a behavioural board RAM (1-cycle read latency).
// Score checks are compiled in only when LINE_CLEAR_SCORE_EN is defined.
module tb_line_clear_engine;
   localparam int ROWS = 22;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        busy;
   logic        done;
   logic [4:0]  lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
   logic        clear_all;
   logic [19:0] score;
`endif

   line_clear_engine_if ram_if ();

   line_clear_engine #(.ROWS(ROWS), .COLS(10), .BASE_ADDR(0)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .lines_cleared (lines_cleared),
`ifdef LINE_CLEAR_SCORE_EN
      .clear_all     (clear_all),
      .score         (score),
`endif
      .ram           (ram_if)
   );

   always #5 clk = ~clk;

   logic [31:0] mem     [ROWS];
   logic [31:0] img     [ROWS];
   logic [31:0] exp_img [ROWS];
   logic        load = 1'b0;

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < ROWS; i++) mem[i] <= img[i];
      end else if (ram_if.RAM_WE) begin
         mem[ram_if.RAM_ROW_ADDR[4:0]] <= ram_if.RAM_WRITEDATA;
      end
      if (ram_if.RAM_RE) ram_if.RAM_READDATA <= mem[ram_if.RAM_ROW_ADDR[4:0]];
   end

   int compared = 0;
   int mismatched = 0;
   int we_cnt, re_cnt, fill_cnt, rd_err, viol, exp_rd;
   logic busy_c0, busy_at_done;
   int dc;
   logic [4:0] lc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic clear_imgs();
      for (int i = 0; i < ROWS; i++) begin
         img[i]     = 32'd0;
         exp_img[i] = 32'd0;
      end
   endtask

   task automatic load_board();
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
   endtask

   task automatic check_board(input string name);
      for (int i = 0; i < ROWS; i++) begin
         check($sformatf("%s_row%0d", name, i), mem[i], exp_img[i]);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_busy"},  {31'd0, busy}, 32'd0);
      check({name, "_done"},  {31'd0, done}, 32'd0);
      check({name, "_re"},    {31'd0, ram_if.RAM_RE}, 32'd0);
      check({name, "_we"},    {31'd0, ram_if.RAM_WE}, 32'd0);
      check({name, "_addr"},  {21'd0, ram_if.RAM_ROW_ADDR}, 32'd0);
      check({name, "_wdata"}, ram_if.RAM_WRITEDATA, 32'd0);
      check({name, "_lines"}, {27'd0, lines_cleared}, 32'd0);
   endtask

   // Start is sampled at edge 0; cycle n is the interval after edge n, observed at its negedge.
   task automatic run_scan(input int pulse_at, input int rst_at);
      we_cnt = 0; re_cnt = 0; fill_cnt = 0; rd_err = 0; viol = 0;
      exp_rd = ROWS - 1; dc = -1; lc = 5'd0; busy_at_done = 1'b0; busy_c0 = 1'b1;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         if (n == 0) busy_c0 = busy;
         if (n == pulse_at) start = 1'b1;
         else if (n == pulse_at + 1) start = 1'b0;
         if (n == rst_at) begin
            reset_n = 1'b0;
            #1 check_idle_outputs("midscan_reset");
            break;
         end
         if (ram_if.RAM_RE && ram_if.RAM_WE) viol++;
         if (!ram_if.RAM_WE && ram_if.RAM_WRITEDATA != 32'd0) viol++;
         if (!ram_if.RAM_RE && !ram_if.RAM_WE && ram_if.RAM_ROW_ADDR != 11'd0) viol++;
         if (ram_if.RAM_RE) begin
            re_cnt++;
            if (ram_if.RAM_ROW_ADDR != 11'(exp_rd)) rd_err++;
            exp_rd--;
         end
         if (ram_if.RAM_WE) begin
            we_cnt++;
            if (n >= 45) fill_cnt++;
         end
         if (done) begin
            dc = n;
            lc = lines_cleared;
            busy_at_done = busy;
            break;
         end
      end
   endtask

   task automatic after_done(input string name, input logic [4:0] exp_lc);
      @(negedge clk);
      check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
      check({name, "_lines_held"}, {27'd0, lines_cleared}, {27'd0, exp_lc});
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
      clear_all = 1'b0;
`endif
      clear_imgs();
      for (int i = 0; i < ROWS; i++) mem[i] = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk) check_idle_outputs("reset");
      reset_n = 1'b1;

      // Empty board
      clear_imgs();
      load_board();
      run_scan(-1, -1);
      check("empty_busy_c0", {31'd0, busy_c0}, 32'd0);
      check("empty_done_cycle", dc, 45);
      check("empty_lines", {27'd0, lc}, 32'd0);
      check("empty_busy_at_done", {31'd0, busy_at_done}, 32'd1);
      check("empty_writes", we_cnt, 0);
      check("empty_reads", re_cnt, 22);
      check("empty_read_order", rd_err, 0);
      check("empty_strobe_rules", viol, 0);
      after_done("empty", 5'd0);
      check_board("empty");

      // Bottom row full, row above it slides down
      clear_imgs();
      img[21] = 32'h000F_FFFF; img[20] = 32'h0000_0003;
      exp_img[21] = 32'h0000_0003;
      load_board();
      run_scan(-1, -1);
      check("one_done_cycle", dc, 46);
      check("one_lines", {27'd0, lc}, 32'd1);
      check("one_writes", we_cnt, 22);
      check("one_strobe_rules", viol, 0);
      after_done("one", 5'd1);
      check_board("one");

      // Four stacked full rows (tetris)
      clear_imgs();
      for (int i = 18; i < 22; i++) img[i] = 32'h000F_FFFF;
      img[17] = 32'h0000_AAAA;
      exp_img[21] = 32'h0000_AAAA;
      load_board();
      run_scan(-1, -1);
      check("four_done_cycle", dc, 49);
      check("four_lines", {27'd0, lc}, 32'd4);
      check("four_fill_writes", fill_cnt, 4);
      check("four_strobe_rules", viol, 0);
      check_board("four");

      // Interleaved full rows
      clear_imgs();
      img[21] = 32'h000F_FFFF; img[20] = 32'h0000_0001;
      img[19] = 32'h000F_FFFF; img[18] = 32'h0000_0002;
      exp_img[21] = 32'h0000_0001; exp_img[20] = 32'h0000_0002;
      load_board();
      run_scan(-1, -1);
      check("split_done_cycle", dc, 47);
      check("split_lines", {27'd0, lc}, 32'd2);
      check("split_fill_writes", fill_cnt, 2);
      check_board("split");

      // Column boundary: only cells 0..9 decide fullness, upper bits copied verbatim
      clear_imgs();
      img[21] = 32'hFFF3_FFFF; img[20] = 32'hFFF0_FFFF; img[19] = 32'h000F_FFFF;
      exp_img[21] = 32'hFFF3_FFFF; exp_img[20] = 32'hFFF0_FFFF;
      load_board();
      run_scan(-1, -1);
      check("cols_done_cycle", dc, 46);
      check("cols_lines", {27'd0, lc}, 32'd1);
      check("cols_writes", we_cnt, 20);
      check_board("cols");

      // All rows full
      clear_imgs();
      for (int i = 0; i < ROWS; i++) img[i] = 32'h000F_FFFF;
      load_board();
      run_scan(-1, -1);
      check("full_done_cycle", dc, 67);
      check("full_lines", {27'd0, lc}, 32'd22);
      check("full_fill_writes", fill_cnt, 22);
      check("full_strobe_rules", viol, 0);
      check_board("full");

      // start during a scan is dropped
      clear_imgs();
      load_board();
      run_scan(10, -1);
      check("ignore_done_cycle", dc, 45);
      begin
         int extra;
         extra = 0;
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done || busy) extra++;
         end
         check("ignore_no_retrigger", extra, 0);
      end

      // Reset in the middle of a scan, then a clean rescan
      run_scan(-1, 20);
      @(negedge clk) reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_reset_busy", {31'd0, busy}, 32'd0);
      run_scan(-1, -1);
      check("recover_done_cycle", dc, 45);
      check("recover_lines", {27'd0, lc}, 32'd0);

`ifdef LINE_CLEAR_SCORE_EN
      @(negedge clk) clear_all = 1'b1;
      @(negedge clk) clear_all = 1'b0;
      check("score_cleared_start", {12'd0, score}, 32'd0);
      for (int r = 0; r < 2; r++) begin
         clear_imgs();
         for (int i = 18; i < 22; i++) img[i] = 32'h000F_FFFF;
         load_board();
         run_scan(-1, -1);
         check("score_scan_lines", {27'd0, lc}, 32'd4);
      end
      @(negedge clk);
      check("score_two_tetris", {12'd0, score}, 32'd1600);
      clear_all = 1'b1;
      @(negedge clk) clear_all = 1'b0;
      check("score_clear_all", {12'd0, score}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
